// File: rtl/fetch_unit.sv
// IF-stage fetch engine: owns the PC, issues one outstanding req/gnt/rvalid
// fetch at a time, and presents (pc, instr, valid) to the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        stall_f,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic [31:0] instr_f,
  output logic        instr_valid_f
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc4;
  logic [XLEN-1:0]   r_instr;
  logic              r_valid;
  logic              r_req;
  logic              r_kill;

  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_pc_next;
  logic              w_unused_tgt_lsb;

  // Redirect targets are word aligned; the two low bits are dropped.
  assign w_target         = {pc_target_e[XLEN-1:2], 2'b00};
  assign w_unused_tgt_lsb = ^pc_target_e[1:0];

  // Next PC: redirect beats stall beats sequential advance (advance only on consume).
  always_comb begin
    w_pc_next = r_pc;
    unique case (r_state)
      S_REQ, S_WAIT: begin
        if (pc_src_e) w_pc_next = w_target;
      end
      S_VALID: begin
        if (pc_src_e)      w_pc_next = w_target;
        else if (!stall_f) w_pc_next = r_pc + XLEN'(4);
      end
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_VEC;
      r_pc4   <= RESET_VEC + XLEN'(4);
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_pc4 <= w_pc_next + XLEN'(4);
      unique case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          // A redirect coinciding with the grant must discard that word later.
          if (imem_gnt) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
            r_kill  <= pc_src_e;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (r_kill || pc_src_e) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_instr <= imem_rdata;
              r_valid <= 1'b1;
              r_state <= S_VALID;
            end
          end else if (pc_src_e) begin
            r_kill <= 1'b1;
          end
        end
        S_VALID: begin
          if (pc_src_e || !stall_f) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_instr <= NOP_INSTR;
          r_kill  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = r_req;
  assign imem_addr     = r_pc;
  assign pc_f          = r_pc;
  assign pc_plus4_f    = r_pc4;
  assign instr_f       = r_instr;
  assign instr_valid_f = r_valid;

endmodule
